// File: rtl/activation_stream_unit.sv
// Two-stage streaming activation unit: per-frame mode latch, four activation modes per lane,
// and a saturating per-frame count of zero output lanes.
module activation_stream_unit #(
  parameter int BITWIDTH   = 32,
  parameter int FRAC_BITS  = 16,
  parameter int CHANNELS   = 2,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data,
  output logic                         out_last,
  output logic [CNT_W-1:0]             zero_count,
  output logic                         frame_done
);

  localparam int DW   = CHANNELS * BITWIDTH;
  localparam int WIDE = BITWIDTH + FRAC_BITS + 4;
  localparam int ZW   = $clog2(CHANNELS + 1);
  localparam int SW   = CNT_W + ZW;

  // ReLU6 ceiling, widened so an overflowing 6<<FRAC_BITS falls back to the largest positive value
  localparam logic [WIDE-1:0]     SIX_WIDE = WIDE'(6) << FRAC_BITS;
  localparam logic [WIDE-1:0]     MAX_WIDE = (WIDE'(1) << (BITWIDTH - 1)) - WIDE'(1);
  localparam logic [BITWIDTH-1:0] MAX_POS  = {1'b0, {(BITWIDTH - 1){1'b1}}};
  localparam logic [BITWIDTH-1:0] CLAMP    = (SIX_WIDE > MAX_WIDE) ? MAX_POS : SIX_WIDE[BITWIDTH-1:0];
  localparam logic [SW-1:0]       SAT      = SW'({CNT_W{1'b1}});

  function automatic logic [BITWIDTH-1:0] activate(input logic [1:0] m, input logic [BITWIDTH-1:0] x);
    logic signed [BITWIDTH-1:0] xs;
    logic [BITWIDTH-1:0]        y;
    xs = x;
    case (m)
      2'd0:    y = x;
      2'd1:    y = x[BITWIDTH-1] ? {BITWIDTH{1'b0}} : x;
      2'd2:    y = x[BITWIDTH-1] ? BITWIDTH'(xs >>> LEAK_SHIFT) : x;
      2'd3:    y = x[BITWIDTH-1] ? {BITWIDTH{1'b0}} : ((x > CLAMP) ? CLAMP : x);
      default: y = x;
    endcase
    return y;
  endfunction

  logic          ready_en;
  logic          in_frame;
  logic [1:0]    frame_mode;
  logic          s1_valid, s1_last, s2_valid, s2_last;
  logic [1:0]    s1_mode;
  logic [DW-1:0] s1_data, s2_data, act_data;
  logic [CNT_W-1:0] acc, zero_count_q;
  logic          frame_done_q;
  logic [ZW-1:0] lane_zeros;
  logic [SW-1:0] acc_sum;
  logic [CNT_W-1:0] acc_sat;
  logic          in_fire, out_fire, s2_load;
  logic [1:0]    beat_mode;

  assign s2_load   = s1_valid & (!s2_valid | out_ready);
  assign in_ready  = ready_en & (!s1_valid | !s2_valid | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = s2_valid & out_ready;
  assign beat_mode = in_frame ? frame_mode : mode;

  assign out_valid  = s2_valid;
  assign out_data   = s2_data;
  assign out_last   = s2_last;
  assign zero_count = zero_count_q;
  assign frame_done = frame_done_q;

  always_comb begin
    act_data = {DW{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      act_data[k*BITWIDTH +: BITWIDTH] = activate(s1_mode, s1_data[k*BITWIDTH +: BITWIDTH]);
    end
  end

  // Zero lanes in the beat currently presented downstream, folded into the saturating accumulator
  always_comb begin
    lane_zeros = {ZW{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      if (s2_data[k*BITWIDTH +: BITWIDTH] == {BITWIDTH{1'b0}}) begin
        lane_zeros = lane_zeros + ZW'(1);
      end else begin
        lane_zeros = lane_zeros;
      end
    end
    acc_sum = SW'(acc) + SW'(lane_zeros);
    acc_sat = (acc_sum > SAT) ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en   <= 1'b0;
      in_frame   <= 1'b0;
      frame_mode <= 2'd0;
      s1_valid   <= 1'b0;
      s1_data    <= {DW{1'b0}};
      s1_last    <= 1'b0;
      s1_mode    <= 2'd0;
    end else begin
      ready_en <= 1'b1;
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_last  <= in_last;
        s1_mode  <= beat_mode;
        in_frame <= !in_last;
        if (!in_frame) begin
          frame_mode <= mode;
        end
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= {DW{1'b0}};
      s2_last  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_data  <= act_data;
      s2_last  <= s1_last;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Frame statistics: the count is published when the closing beat leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= {CNT_W{1'b0}};
      zero_count_q <= {CNT_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_fire & s2_last;
      if (out_fire && s2_last) begin
        zero_count_q <= acc_sat;
        acc          <= {CNT_W{1'b0}};
      end else if (out_fire) begin
        acc <= acc_sat;
      end
    end
  end

endmodule
